// File: rtl/ysyx_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_ifu
//  Purpose  : Instruction fetch unit for the ysyx multi-cycle core. Holds the
//             PC, issues one instruction-memory read at a time and hands
//             {inst, pc, fault} to the decoder over a valid/ready handshake.
//             Redirects from execute/writeback flush in-flight work.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk             in   1   single clock, all state on posedge
//    rst_n           in   1   synchronous active-low reset
//    imem_req_valid  out  1   read request valid (REQ state)
//    imem_req_ready  in   1   memory accepts request
//    imem_req_addr   out  32  word-aligned fetch address (= pc)
//    imem_rsp_valid  in   1   read data valid
//    imem_rsp_ready  out  1   IFU accepts response (WAIT state)
//    imem_rsp_data   in   32  instruction word
//    imem_rsp_err    in   1   access fault for this response
//    out_valid       out  1   {out_inst,out_pc} valid to decoder (HOLD state)
//    out_ready       in   1   decoder consumes
//    out_inst        out  32  fetched instruction (NOP_INST on fault)
//    out_pc          out  32  PC of out_inst
//    out_fault       out  1   fetch access fault flag for out_inst
//    redirect_valid  in   1   one-cycle pulse: flush and refetch
//    redirect_pc     in   32  new PC; bits [1:0] are cleared
// ============================================================================
module ysyx_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory request channel
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  // instruction memory response channel
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  // decoder channel
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_fault,
  // redirect from execute / writeback
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_drop;   // outstanding response belongs to a flushed fetch
  logic [31:0] r_inst;
  logic        r_fault;

  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_seq;

  // Masking keeps the PC word aligned without leaving redirect_pc[1:0] unread.
  assign w_redirect_pc = redirect_pc & ~32'h0000_0003;
  // Natural 32-bit wrap gives the required modulo-2^32 PC arithmetic.
  assign w_pc_seq      = r_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_drop  <= 1'b0;
      r_inst  <= NOP_INST;
      r_fault <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_REQ;
        end

        ST_REQ: begin
          if (imem_req_ready) begin
            r_state <= ST_WAIT;
            // The request for the old PC is already in memory; its
            // response must be thrown away when it arrives.
            if (redirect_valid) begin
              r_drop <= 1'b1;
              r_pc   <= w_redirect_pc;
            end
          end else if (redirect_valid) begin
            // Nothing accepted yet, so simply retarget the pending request.
            r_pc <= w_redirect_pc;
          end
        end

        ST_WAIT: begin
          if (redirect_valid) begin
            r_pc <= w_redirect_pc;
          end
          if (imem_rsp_valid) begin
            if (r_drop || redirect_valid) begin
              // Stale word: discard and start the fetch at the new PC.
              r_state <= ST_REQ;
              r_drop  <= 1'b0;
            end else begin
              r_state <= ST_HOLD;
              r_inst  <= imem_rsp_err ? NOP_INST : imem_rsp_data;
              r_fault <= imem_rsp_err;
            end
          end else if (redirect_valid) begin
            r_drop <= 1'b1;
          end
        end

        ST_HOLD: begin
          // A redirect wins over the sequential PC whether or not the
          // decoder took the instruction in the same cycle.
          if (redirect_valid) begin
            r_state <= ST_REQ;
            r_pc    <= w_redirect_pc;
          end else if (out_ready) begin
            r_state <= ST_REQ;
            r_pc    <= w_pc_seq;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs are decoded from registered state only.
  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_req_addr  = r_pc;
  assign imem_rsp_ready = (r_state == ST_WAIT);
  assign out_valid      = (r_state == ST_HOLD);
  assign out_inst       = r_inst;
  assign out_pc         = r_pc;
  assign out_fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_ifu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_ifu
//  Purpose  : Self-checking bench for ysyx_ifu. Stimulus pushes expected
//             request addresses and decoder transfers into queues; a monitor
//             pops and compares on every handshake. A small memory model
//             answers requests with data {8'hAB, addr[23:0]} (0x00000093 at
//             0x80000000) after a programmable latency.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_ifu;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic        imem_rsp_ready;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int tests;
  int fails;

  logic [31:0] exp_req_q[$];
  logic [64:0] exp_out_q[$];   // {fault, inst, pc}

  // memory model state
  logic        mem_auto;
  int          mem_lat;
  logic [31:0] err_addr;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_err;
  // manual response override
  logic        man_mode;
  logic        man_valid;
  logic [31:0] man_data;

  assign imem_rsp_valid = man_mode ? man_valid : m_valid;
  assign imem_rsp_data  = man_mode ? man_data  : m_data;
  assign imem_rsp_err   = man_mode ? 1'b0      : m_err;

  ysyx_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_ready (imem_rsp_ready),
    .imem_rsp_data  (imem_rsp_data),
    .imem_rsp_err   (imem_rsp_err),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .out_fault      (out_fault),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0093;
    return {8'hAB, a[23:0]};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [31:0] e_addr;
    logic [64:0] e_out;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (imem_req_valid === 1'b1 && imem_req_ready === 1'b1) begin
          if (exp_req_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_req: got addr %h, expected no request", imem_req_addr);
          end else begin
            e_addr = exp_req_q.pop_front();
            chk("req_addr", imem_req_addr, e_addr);
          end
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          if (exp_out_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_out: got inst %h pc %h, expected no transfer", out_inst, out_pc);
          end else begin
            e_out = exp_out_q.pop_front();
            chk("out_inst",  out_inst,        e_out[63:32]);
            chk("out_pc",    out_pc,          e_out[31:0]);
            chk("out_fault", 32'(out_fault),  32'(e_out[64]));
          end
        end
      end
    end
  end

  // ---------------- memory model ----------------
  initial begin
    logic        s_rst;
    logic        s_rq;
    logic        s_rv;
    logic [31:0] s_addr;
    logic        busy;
    logic [31:0] paddr;
    int          cnt;
    m_valid = 1'b0;
    m_data  = 32'h0;
    m_err   = 1'b0;
    busy    = 1'b0;
    paddr   = 32'h0;
    cnt     = 0;
    forever begin
      @(negedge clk);
      s_rst  = rst_n;
      s_rq   = (imem_req_valid === 1'b1) && (imem_req_ready === 1'b1);
      s_rv   = (imem_rsp_valid === 1'b1) && (imem_rsp_ready === 1'b1);
      s_addr = imem_req_addr;
      @(posedge clk);
      #1;
      if (s_rst !== 1'b1) begin
        m_valid = 1'b0;
        busy    = 1'b0;
      end else if (mem_auto) begin
        if (s_rv) begin
          m_valid = 1'b0;
          busy    = 1'b0;
        end
        if (s_rq) begin
          busy  = 1'b1;
          paddr = s_addr;
          cnt   = mem_lat - 1;
        end
        if (busy && !m_valid) begin
          if (cnt == 0) begin
            m_valid = 1'b1;
            m_data  = mem_word(paddr);
            m_err   = (paddr == err_addr);
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string name);
    for (int i = 0; i < 30; i++) begin
      if (out_valid === 1'b1) break;
      tick();
    end
    chk(name, 32'(out_valid), 32'd1);
  endtask

  task automatic accept(input logic [31:0] inst, input logic [31:0] pc,
                        input logic fault, input logic [31:0] next_req);
    exp_out_q.push_back({fault, inst, pc});
    exp_req_q.push_back(next_req);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    tests          = 0;
    fails          = 0;
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_auto       = 1'b1;
    mem_lat        = 1;
    err_addr       = 32'h0000_0001;
    man_mode       = 1'b0;
    man_valid      = 1'b0;
    man_data       = 32'h0;

    repeat (3) tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid),      32'd0);
    chk("rst_out_pc",    out_pc,              32'h8000_0000);
    chk("rst_req_addr",  imem_req_addr,       32'h8000_0000);

    // 1: first fetch after reset
    exp_req_q.push_back(32'h8000_0000);
    rst_n = 1'b1;
    wait_out("t1_valid");
    chk("t1_inst", out_inst, 32'h0000_0093);
    chk("t1_pc",   out_pc,   32'h8000_0000);

    // 2: decoder stalls 5 cycles in HOLD
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t2_inst_stable", out_inst, 32'h0000_0093);
      chk("t2_pc_stable",   out_pc,   32'h8000_0000);
      chk("t2_no_req",      32'(imem_req_valid), 32'd0);
    end
    accept(32'h0000_0093, 32'h8000_0000, 1'b0, 32'h8000_0004);
    wait_out("t2_next_valid");
    chk("t2_next_inst", out_inst, 32'hAB00_0004);

    // 3: redirect while WAIT, response 4 cycles after accept is dropped
    mem_lat = 4;
    accept(32'hAB00_0004, 32'h8000_0004, 1'b0, 32'h8000_0008);
    tick();                                  // now in WAIT
    chk("t3_in_wait", 32'(imem_rsp_ready), 32'd1);
    exp_req_q.push_back(32'h8000_0100);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    chk("t3_pc_redirected", imem_req_addr, 32'h8000_0100);
    wait_out("t3_valid");
    chk("t3_pc",   out_pc,   32'h8000_0100);
    chk("t3_inst", out_inst, 32'hAB00_0100);

    // 4: fetch fault at 0x80000008 (reached via redirect, HOLD word discarded)
    mem_lat  = 1;
    err_addr = 32'h8000_0008;
    exp_req_q.push_back(32'h8000_0008);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0008;
    tick();
    redirect_valid = 1'b0;
    wait_out("t4_valid");
    chk("t4_inst",  out_inst,         32'h0000_0013);
    chk("t4_fault", 32'(out_fault),   32'd1);
    chk("t4_pc",    out_pc,           32'h8000_0008);
    accept(32'h0000_0013, 32'h8000_0008, 1'b1, 32'h8000_000C);
    wait_out("t4_next_valid");
    chk("t4_next_fault", 32'(out_fault), 32'd0);
    chk("t4_next_pc",    out_pc,         32'h8000_000C);

    // 5: unaligned redirect near top of address space, then wrap
    exp_req_q.push_back(32'hFFFF_FFFC);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFE;
    tick();
    redirect_valid = 1'b0;
    wait_out("t5_valid");
    chk("t5_pc",   out_pc,   32'hFFFF_FFFC);
    chk("t5_inst", out_inst, 32'hABFF_FFFC);
    accept(32'hABFF_FFFC, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);
    wait_out("t5_wrap_valid");
    chk("t5_wrap_pc", out_pc, 32'h0000_0000);

    // 5b: redirect while request not yet accepted retargets the address
    exp_out_q.push_back({1'b0, 32'hAB00_0000, 32'h0000_0000});
    imem_req_ready = 1'b0;
    out_ready      = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t5b_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t5b_addr_seq",  imem_req_addr,       32'h0000_0004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    tick();
    redirect_valid = 1'b0;
    chk("t5b_addr_redir", imem_req_addr, 32'h8000_0200);
    exp_req_q.push_back(32'h8000_0200);
    imem_req_ready = 1'b1;
    wait_out("t5b_valid");
    chk("t5b_inst", out_inst, 32'hAB00_0200);

    // 6b: redirect and out_ready together in HOLD -> redirect PC, word consumed
    exp_out_q.push_back({1'b0, 32'hAB00_0200, 32'h8000_0200});
    exp_req_q.push_back(32'h8000_0300);
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    tick();
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    mem_auto       = 1'b0;
    chk("t6_redir_addr", imem_req_addr, 32'h8000_0300);

    // 6a: reset during WAIT while a response is presented
    tick();                                  // now in WAIT
    chk("t6_in_wait", 32'(imem_rsp_ready), 32'd1);
    man_mode  = 1'b1;
    man_valid = 1'b1;
    man_data  = 32'hDEAD_BEEF;
    rst_n     = 1'b0;
    tick();
    chk("t6_rst_out_valid", 32'(out_valid),      32'd0);
    chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("t6_rst_rsp_ready", 32'(imem_rsp_ready), 32'd0);
    chk("t6_rst_pc",        out_pc,              32'h8000_0000);
    exp_req_q.push_back(32'h8000_0000);
    rst_n = 1'b1;
    tick();                                  // IDLE -> REQ, stray response ignored
    man_mode  = 1'b0;
    man_valid = 1'b0;
    mem_auto  = 1'b1;
    chk("t6_req_valid", 32'(imem_req_valid), 32'd1);
    chk("t6_req_addr",  imem_req_addr,       32'h8000_0000);
    wait_out("t6_valid");
    chk("t6_inst", out_inst, 32'h0000_0093);
    accept(32'h0000_0093, 32'h8000_0000, 1'b0, 32'h8000_0004);
    wait_out("t6_next_valid");
    chk("t6_next_pc", out_pc, 32'h8000_0004);

    tick();
    chk("end_req_q_empty", 32'(exp_req_q.size()), 32'd0);
    chk("end_out_q_empty", 32'(exp_out_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
